pipe_stage_elastic: RTL
=======================

// Module: pipe_stage_elastic
// PURPOSE
//   Parametrised elastic pipeline register that replaces the fixed-field, always-enabled
//   inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB).
//   Carries an opaque WIDTH-bit packed bundle of datapath and control fields through DEPTH
//   register stages.
//   Uses a valid/ready handshake, so a stall back-pressures upstream stage by stage.
//   Flush squashes every in-flight entry; squashed and bubble entries carry all-zero data
//   (no stray regWEN/dMemWEN/Halt).
// PARAMETERS
//   WIDTH   128  bits of packed bundle per entry (>=1)
//   DEPTH   1    number of register stages, input-to-output latency in cycles (>=1)
//   CNT_W   32   width of saturating stall counter
// PORTS
//   CLK        in   1                    rising-edge clock
//   RST        in   1                    synchronous reset, active-high
//   in_valid   in   1                    upstream presents an entry
//   in_ready   out  1                    stage 0 can accept this cycle
//   in_data    in   WIDTH                upstream bundle
//   flush      in   1                    squash all stages (branch/jump resolve)
//   out_valid  out  1                    last stage holds a valid entry
//   out_ready  in   1                    downstream accepts this cycle
//   out_data   out  WIDTH                last-stage bundle (zero when !out_valid)
//   occupancy  out  $clog2(DEPTH+1)      count of valid stages
//   stall_cnt  out  CNT_W                cycles with out_valid && !out_ready
// BEHAVIOUR
//   State per stage i (0..DEPTH-1):
//   - v[i]: valid bit; d[i]: WIDTH-bit bundle. Stage DEPTH-1 drives out_valid/out_data.
//   Advance chain (combinational, from the output backward):
//   - adv[DEPTH-1] = !v[DEPTH-1] | out_ready
//   - adv[i] = !v[i] | adv[i+1]
//   - in_ready = adv[0] & !flush
//   - An empty stage always accepts. A full stage accepts only if its successor moves.
//     This gives full throughput with no bubble penalty.
//   Per-cycle update, in priority order:
//   1. RST: all v=0, all d=0, stall_cnt=0. Outputs after reset:
//      out_valid=0, out_data=0, in_ready=1, occupancy=0.
//   2. flush (and !RST): all v=0, all d=0 at the next edge. in_data is not captured.
//      - An out_valid&&out_ready transfer in the flush cycle is still a completed
//        transfer; downstream owns that entry.
//      - stall_cnt is not cleared by flush.
//   3. Otherwise, for each stage with adv[i]=1:
//      - v[i] <= src_valid, where src is in_valid (i=0) or v[i-1] (i>0).
//      - d[i] <= src_valid ? src_data : 0, so bubbles are zero.
//      - A stage with adv[i]=0 holds v[i] and d[i].
//   Latency and handshake:
//   - Latency with no back-pressure is exactly DEPTH cycles.
//   - An entry accepted at edge t appears on out_valid after edge t+DEPTH-1.
//   - Upstream must hold in_data and in_valid stable while in_valid && !in_ready.
//     Downstream may drop out_ready at any time.
//   - No entry is duplicated, reordered or lost except by flush or RST.
//   stall_cnt:
//   - Increments when out_valid && !out_ready and !RST.
//   - Saturates at 2^CNT_W-1 (no wrap).
//   occupancy = popcount(v). Never exceeds DEPTH.
//   Boundaries:
//   - Full, out_ready=0: in_ready=0 and all stages hold.
//   - Full with out_ready=1: in_ready=1 and the whole pipe shifts by one in the same cycle.
//   - flush with RST: RST wins, with identical visible result.
//   - RST mid-stall: in-flight entries are discarded, and stall_cnt resets to 0.
// TESTING
//   T1 DEPTH=1, in_valid=1 data 0xA5.., out_ready=1 -> out_valid=1, out_data=0xA5.. one
//      cycle later; in_ready=1 every cycle.
//   T2 DEPTH=3, stream 1,2,3,4,5 with out_ready=1 -> outputs 1..5 in order, first at
//      cycle 3, no gaps.
//   T3 DEPTH=3, fill 3 entries, then hold out_ready=0 for 4 cycles:
//      - in_ready=0, occupancy=3, out_data stable, stall_cnt=4.
//      - Release -> entries drain in order.
//   T4 DEPTH=3, 2 entries in flight, pulse flush with in_valid=1:
//      - Next cycle occupancy=0, out_valid=0, out_data=0.
//      - in_ready=0 during the flush cycle; the flushed input never appears.
//   T5 CNT_W=4, out_valid=1 and out_ready=0 held 20 cycles -> stall_cnt saturates at 15.
//   T6 RST asserted mid-stall with 2 entries held -> next cycle all outputs at reset
//      values; a new stream afterwards passes normally.

Source files
------------

// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic
//   Elastic pipeline register carrying an opaque WIDTH-bit bundle through DEPTH
//   register stages with a valid/ready handshake. A stall back-pressures upstream
//   one stage at a time. Empty stages always accept, so there is no bubble penalty.
//   Flush squashes every in-flight entry. Bubble and squashed entries carry all-zero
//   data, so they can never assert a stray write enable or halt downstream.
//
// Ports
//   CLK        rising-edge clock
//   RST        synchronous reset, active-high
//   in_valid   upstream presents an entry
//   in_ready   stage 0 can accept this cycle
//   in_data    upstream bundle
//   flush      squash all stages at the next edge
//   out_valid  last stage holds a valid entry
//   out_ready  downstream accepts this cycle
//   out_data   last-stage bundle, zero when !out_valid
//   occupancy  number of valid stages
//   stall_cnt  saturating count of cycles with out_valid && !out_ready
module pipe_stage_elastic #(
   parameter int unsigned WIDTH = 128,
   parameter int unsigned DEPTH = 1,
   parameter int unsigned CNT_W = 32
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           in_data,
   input  logic                       flush,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_data,
   output logic [$clog2(DEPTH+1)-1:0] occupancy,
   output logic [CNT_W-1:0]           stall_cnt
);

   localparam int unsigned OCC_W = $clog2(DEPTH + 1);

   logic [DEPTH-1:0] v_q;
   logic [DEPTH-1:0] v_d;
   logic [DEPTH-1:0] adv;
   logic [DEPTH-1:0] src_v;
   logic [WIDTH-1:0] d_q   [DEPTH];
   logic [WIDTH-1:0] d_d   [DEPTH];
   logic [WIDTH-1:0] src_d [DEPTH];
   logic [CNT_W-1:0] stall_q;

   // A stage may load when it is empty or every stage ahead of it can move.
   // Accumulated in a local so the chain is a plain OR-reduction, not a self-loop.
   always_comb begin : adv_chain
      logic acc;
      acc = out_ready;
      adv = '0;
      for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
         acc    = acc | ~v_q[i];
         adv[i] = acc;
      end
   end

   // Source of each stage: the upstream port for stage 0, else the previous stage.
   always_comb begin
      src_v[0] = in_valid;
      src_d[0] = in_data;
      for (int i = 1; i < int'(DEPTH); i++) begin
         src_v[i] = v_q[i-1];
         src_d[i] = d_q[i-1];
      end
   end

   always_comb begin
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (flush) begin
            v_d[i] = 1'b0;
            d_d[i] = '0;
         end else if (adv[i]) begin
            v_d[i] = src_v[i];
            // Bubbles are forced to zero so no control field leaks through.
            d_d[i] = src_v[i] ? src_d[i] : '0;
         end else begin
            v_d[i] = v_q[i];
            d_d[i] = d_q[i];
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         v_q <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            d_q[i] <= '0;
         end
      end else begin
         v_q <= v_d;
         for (int i = 0; i < int'(DEPTH); i++) begin
            d_q[i] <= d_d[i];
         end
      end
   end

   // Flush does not clear the counter; it only measures downstream back-pressure.
   always_ff @(posedge CLK) begin
      if (RST) begin
         stall_q <= '0;
      end else if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
         stall_q <= stall_q + CNT_W'(1);
      end
   end

   always_comb begin
      occupancy = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         occupancy = occupancy + OCC_W'(v_q[i]);
      end
   end

   assign out_valid = v_q[DEPTH-1];
   assign out_data  = out_valid ? d_q[DEPTH-1] : '0;
   assign in_ready  = adv[0] & ~flush;
   assign stall_cnt = stall_q;

endmodule
